// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM shared by two datapath agents on one clock.
// Registered reads; same-port write-first, cross-port read-first, port A wins write-write collisions.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_r;
  logic [DATA_WIDTH-1:0] dout_b_r;

  logic                  collide_s;
  logic                  wr_b_en_s;
  logic [DATA_WIDTH-1:0] rd_a_next_s;
  logic [DATA_WIDTH-1:0] rd_b_next_s;

  // Resolve collisions and select next read data for both ports.
  always_comb begin
    collide_s   = 1'b0;
    wr_b_en_s   = 1'b0;
    rd_a_next_s = mem_r[addr_a];
    rd_b_next_s = mem_r[addr_b];
    if (we_a && we_b && (addr_a == addr_b)) begin
      collide_s = 1'b1;
    end else begin
      collide_s = 1'b0;
    end
    wr_b_en_s = we_b & ~collide_s;
    if (we_a) begin
      rd_a_next_s = din_a;
    end else begin
      rd_a_next_s = mem_r[addr_a];
    end
    // A writing port returns what was actually stored, so a losing port B sees din_a.
    if (we_b && collide_s) begin
      rd_b_next_s = din_a;
    end else if (we_b) begin
      rd_b_next_s = din_b;
    end else begin
      rd_b_next_s = mem_r[addr_b];
    end
  end

  // Storage array and registered read ports, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_WIDTH'(0);
      end
      dout_a_r <= DATA_WIDTH'(0);
      dout_b_r <= DATA_WIDTH'(0);
    end else begin
      if (wr_b_en_s) begin
        mem_r[addr_b] <= din_b;
      end
      if (we_a) begin
        mem_r[addr_a] <= din_a;
      end
      dout_a_r <= rd_a_next_s;
      dout_b_r <= rd_b_next_s;
    end
  end

  assign dout_a = dout_a_r;
  assign dout_b = dout_b_r;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed scenarios plus randomized traffic
// compared against an array-based reference model of the collision rules.
module tb_dual_port_ram;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          we_a;
  logic          we_b;
  logic [DW-1:0] din_a;
  logic [DW-1:0] din_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] dout_a;
  logic [DW-1:0] dout_b;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;

  int checks = 0;
  int errors = 0;

  dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_a   (we_a),
    .we_b   (we_b),
    .din_a  (din_a),
    .din_b  (din_b),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .dout_a (dout_a),
    .dout_b (dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    exp_a = 8'h00;
    exp_b = 8'h00;
  endtask

  // Apply one cycle of inputs, advance the model across the edge and compare both ports.
  task automatic cycle(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input string tag);
    logic [DW-1:0] old_a;
    logic [DW-1:0] old_b;
    we_a = wa; addr_a = aa; din_a = da;
    we_b = wb; addr_b = ab; din_b = db;
    @(posedge clk);
    if (rst_n) begin
      old_a = model_mem[aa];
      old_b = model_mem[ab];
      if (wb) model_mem[ab] = db;
      if (wa) model_mem[aa] = da;   // port A applied last, so it wins a same-address clash
      exp_a = wa ? model_mem[aa] : old_a;
      exp_b = wb ? model_mem[ab] : old_b;
    end else begin
      exp_a = 8'h00;
      exp_b = 8'h00;
    end
    #1;
    check({tag, "_a"}, dout_a, exp_a);
    check({tag, "_b"}, dout_b, exp_b);
  endtask

  initial begin
    rst_n = 1'b0;
    we_a = 1'b0; we_b = 1'b0;
    din_a = 8'h00; din_b = 8'h00;
    addr_a = 4'd0; addr_b = 4'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout_a", dout_a, 8'h00);
    check("reset_dout_b", dout_b, 8'h00);
    rst_n = 1'b1;

    // Test 1: write then asynchronous mid-cycle reset.
    cycle(1'b1, 4'd2, 8'hAA, 1'b0, 4'd0, 8'h00, "t1_wr");
    check("t1_wr_first", dout_a, 8'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("t1_async_a", dout_a, 8'h00);
    check("t1_async_b", dout_b, 8'h00);
    cycle(1'b1, 4'd5, 8'h77, 1'b1, 4'd6, 8'h99, "t1_in_rst");
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 4'd2, 8'h00, 1'b0, 4'd2, 8'h00, "t1_rd2");
    check("t1_rd2_lit_a", dout_a, 8'h00);
    check("t1_rd2_lit_b", dout_b, 8'h00);
    cycle(1'b0, 4'd5, 8'h00, 1'b0, 4'd6, 8'h00, "t1_rd56");
    check("t1_ignored_a", dout_a, 8'h00);
    check("t1_ignored_b", dout_b, 8'h00);

    // Test 2: write on A, read on B, and output hold between edges.
    cycle(1'b1, 4'd2, 8'hAA, 1'b0, 4'd0, 8'h00, "t2_wr");
    check("t2_wr_first", dout_a, 8'hAA);
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd2, 8'h00, "t2_rd");
    check("t2_rd_b", dout_b, 8'hAA);
    addr_b = 4'd0;
    #3;
    check("t2_hold_b", dout_b, 8'hAA);

    // Test 3: concurrent independent writes.
    cycle(1'b1, 4'd4, 8'h55, 1'b1, 4'd6, 8'h66, "t3_wr");
    check("t3_wr_a", dout_a, 8'h55);
    check("t3_wr_b", dout_b, 8'h66);
    cycle(1'b0, 4'd4, 8'h00, 1'b0, 4'd6, 8'h00, "t3_rd");
    check("t3_rd_a", dout_a, 8'h55);
    check("t3_rd_b", dout_b, 8'h66);

    // Test 4: write-write collision, port A wins.
    cycle(1'b1, 4'd8, 8'hF0, 1'b1, 4'd8, 8'h0F, "t4_ww");
    check("t4_ww_a", dout_a, 8'hF0);
    check("t4_ww_b", dout_b, 8'hF0);
    cycle(1'b0, 4'd8, 8'h00, 1'b0, 4'd8, 8'h00, "t4_rd");
    check("t4_rd_a", dout_a, 8'hF0);
    check("t4_rd_b", dout_b, 8'hF0);

    // Test 5: cross-port read-during-write returns old data.
    cycle(1'b1, 4'd3, 8'h11, 1'b0, 4'd0, 8'h00, "t5_init");
    cycle(1'b1, 4'd3, 8'h22, 1'b0, 4'd3, 8'h00, "t5_rdw");
    check("t5_old_b", dout_b, 8'h11);
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 8'h00, "t5_new");
    check("t5_new_b", dout_b, 8'h22);

    // Cross-port the other way: B writes while A reads.
    cycle(1'b0, 4'd3, 8'h00, 1'b1, 4'd3, 8'h33, "t5_rdw_ba");
    check("t5_old_a", dout_a, 8'h22);

    // Test 6: sweep write on A, read back on B.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, AW'(i), DW'(i) ^ 8'h5A, 1'b0, 4'd0, 8'h00, "t6_wr");
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 4'd0, 8'h00, 1'b0, AW'(i), 8'h00, "t6_rd");
      check("t6_sweep", dout_b, DW'(i) ^ 8'h5A);
    end

    // Randomized traffic; a narrow address window half the time forces collisions.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      if ($urandom_range(0, 1) == 0) begin
        ra = AW'($urandom_range(0, 1));
        rb = AW'($urandom_range(0, 1));
      end else begin
        ra = AW'($urandom_range(0, DEPTH - 1));
        rb = AW'($urandom_range(0, DEPTH - 1));
      end
      cycle(1'($urandom_range(0, 1)), ra, DW'($urandom),
            1'($urandom_range(0, 1)), rb, DW'($urandom), "rnd");
    end

    // Final readback of the whole array through both ports.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, AW'(i), 8'h00, 1'b0, AW'(DEPTH - 1 - i), 8'h00, "final");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- True dual-port synchronous RAM, default 16 words x 8 bits, with two independent read/write ports (A and B) on one shared clock.
- Each port can write or read any address every cycle.
- Used as a small shared scratch buffer between two datapath agents.
- Deterministic same-address collision rules and an asynchronous clear.

Parameters:
- DATA_WIDTH, 8, width of each word and of din/dout.
- ADDR_WIDTH, 4, address width.
- DEPTH, 2**ADDR_WIDTH (16), number of words. Every address in the range is valid.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we_a  input  1  port A write enable.
- we_b  input  1  port B write enable.
- din_a  input  DATA_WIDTH  port A write data.
- din_b  input  DATA_WIDTH  port B write data.
- addr_a  input  ADDR_WIDTH  port A address.
- addr_b  input  ADDR_WIDTH  port B address.
- dout_a  output  DATA_WIDTH  port A registered read data.
- dout_b  output  DATA_WIDTH  port B registered read data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - rst_n low immediately clears every memory word to 0 and clears dout_a and dout_b to 0, without waiting for a clock edge.
  - While rst_n is low, writes are ignored.
  - On release, normal operation starts at the next rising edge.
  - Reset asserted mid-write discards that write.
- Write: on a rising edge with we_x=1, mem[addr_x] <= din_x.
- Read:
  - Every rising edge updates dout_x; there is no read enable.
  - Latency is 1 cycle: dout_x reflects the address sampled at edge N, valid after edge N.
  - dout_x holds its value between edges.
- Same-port read-during-write (write-first): with we_x=1, dout_x <= value actually stored at addr_x at that edge (normally din_x).
- Cross-port read-during-write (read-first):
  - Condition: port X reads (we_x=0) an address that port Y writes in the same cycle.
  - dout_x <= old memory contents.
  - The new data becomes visible to port X from the next access onward.
- Write-write collision:
  - Condition: we_a=we_b=1 and addr_a==addr_b.
  - Port A wins: mem <= din_a; din_b is discarded.
  - Both dout_a and dout_b <= din_a (each writing port returns the stored value).
- Different addresses: both writes complete in the same cycle, fully independent.
- Both ports reading the same address: both return the same word; no arbitration.
- Address arithmetic is unsigned with no wrap logic needed; ADDR_WIDTH bits cover DEPTH exactly.
- No X propagation: uninitialised reads are impossible after reset.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle after writing 8'hAA to addr 2 -> dout_a=dout_b=0 immediately. After release, reading addr 2 on either port returns 8'h00.
2. Write A / read B: we_a=1, addr_a=2, din_a=8'hAA for one edge; then we_a=0, addr_b=2 -> dout_a=8'hAA after the write edge (write-first). dout_b=8'hAA one cycle after addr_b is presented.
3. Concurrent independent writes: we_a=1, addr_a=4, din_a=8'h55; we_b=1, addr_b=6, din_b=8'h66 -> after the edge, dout_a=8'h55 and dout_b=8'h66. Later reads with addr_a=4, addr_b=6 return 8'h55 and 8'h66.
4. Write-write collision: we_a=we_b=1, addr_a=addr_b=8, din_a=8'hF0, din_b=8'h0F -> mem[8]=8'hF0 and dout_a=dout_b=8'hF0. A subsequent read of addr 8 on either port returns 8'hF0.
5. Cross-port read-during-write: mem[3]=8'h11; in the same edge port A writes 8'h22 to addr 3 while port B reads addr 3 -> dout_b=8'h11. On the next edge, dout_b=8'h22.
6. Sweep: port A writes address i with data i^8'h5A for i=0..15, then port B reads 0..15 -> each returns i^8'h5A with 1-cycle latency, and no other word is corrupted.
